// File: rtl/tile_pkg.sv
// tile_pkg: shared types and default geometry for the falling-tile lanes.
//   lane_state_t : per-lane FSM state (IDLE, FALL)
//   Y_W          : width of a tile's top-row position
//   *_D          : default screen geometry used as parameter defaults
`timescale 1ns/1ps
package tile_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FALL = 1'b1
  } lane_state_t;

  localparam int Y_W        = 10;
  localparam int Y_MAX_D    = 479;
  localparam int TILE_H_D   = 120;
  localparam int HIT_LINE_D = 400;

endpackage

// File: rtl/tile_lane.sv
// tile_lane: one falling-tile lane. Holds the lane FSM, the tile's top-row
// position and the registered one-frame event pulses.
// Ports:
//   frame_clk   - frame clock, one tick per video frame
//   Reset       - asynchronous reset, active-high
//   spawn       - launch a tile at the top (ignored while falling)
//   key_hit     - one-frame key pulse for this lane
//   speed       - rows advanced per frame
//   tile_y      - registered top-row position
//   tile_active - registered: lane holds a falling tile
//   hit_ok      - pulse: tile hit inside the window
//   hit_bad     - pulse: key pressed without a hittable tile
//   miss        - pulse: tile left the screen unhit
//   hit_now     - combinational: a hit is being accepted at the coming edge
//                 (lets the score update on the same edge as hit_ok)
// Optional feature: TILE_LANES_WRAP_EN - an unhit tile wraps to the top and
// keeps falling instead of returning to IDLE.
`timescale 1ns/1ps
module tile_lane
  import tile_pkg::*;
#(
  parameter int Y_MAX    = Y_MAX_D,
  parameter int TILE_H   = TILE_H_D,
  parameter int HIT_LINE = HIT_LINE_D,
  parameter int SPEED_W  = 4
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               spawn,
  input  logic               key_hit,
  input  logic [SPEED_W-1:0] speed,
  output logic [Y_W-1:0]     tile_y,
  output logic               tile_active,
  output logic               hit_ok,
  output logic               hit_bad,
  output logic               miss,
  output logic               hit_now
);

  // One extra bit so y+speed and y+TILE_H never wrap.
  localparam logic [Y_W:0] Y_MAX_L    = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W:0] TILE_H_L   = (Y_W+1)'(TILE_H);
  localparam logic [Y_W:0] HIT_LINE_L = (Y_W+1)'(HIT_LINE);

  lane_state_t    state;
  logic [Y_W:0]   y_ext;
  logic [Y_W:0]   y_step;
  logic           in_window;

  assign y_ext     = {1'b0, tile_y};
  assign y_step    = y_ext + (Y_W+1)'(speed);
  assign in_window = (y_ext + TILE_H_L) > HIT_LINE_L;
  assign hit_now   = (state == FALL) && key_hit && in_window;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      tile_y      <= '0;
      tile_active <= 1'b0;
      hit_ok      <= 1'b0;
      hit_bad     <= 1'b0;
      miss        <= 1'b0;
    end else begin
      hit_ok  <= 1'b0;
      hit_bad <= 1'b0;
      miss    <= 1'b0;
      case (state)
        IDLE: begin
          tile_y  <= '0;
          hit_bad <= key_hit;
          if (spawn) begin
            state       <= FALL;
            tile_active <= 1'b1;
          end
        end
        FALL: begin
          if (hit_now) begin
            // A hit takes priority over a simultaneous miss.
            hit_ok      <= 1'b1;
            state       <= IDLE;
            tile_active <= 1'b0;
            tile_y      <= '0;
          end else begin
            // An early key press is flagged but the tile keeps moving.
            hit_bad <= key_hit;
            if (y_step > Y_MAX_L) begin
              miss   <= 1'b1;
              tile_y <= '0;
`ifdef TILE_LANES_WRAP_EN
              state       <= FALL;
              tile_active <= 1'b1;
`else
              state       <= IDLE;
              tile_active <= 1'b0;
`endif
            end else begin
              tile_y <= y_step[Y_W-1:0];
            end
          end
        end
        default: begin
          state       <= IDLE;
          tile_active <= 1'b0;
          tile_y      <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tile_lanes.sv
// tile_lanes: LANES independent falling-tile lanes plus a shared score.
// Ports:
//   frame_clk   - frame clock, one tick per video frame
//   Reset       - asynchronous reset, active-high
//   spawn       - per-lane tile launch request
//   key_hit     - per-lane one-frame key pulse
//   speed       - rows advanced per frame, shared by all lanes
//   tile_y      - packed top-row positions, lane i at [10i+9:10i]
//   tile_active - per-lane falling-tile flag
//   hit_ok      - per-lane pulse: hit inside the window
//   hit_bad     - per-lane pulse: key with no hittable tile
//   miss        - per-lane pulse: tile left the screen unhit
//   score       - saturating hit count
// Optional feature: TILE_LANES_WRAP_EN (see tile_lane) - unhit tiles wrap.
`timescale 1ns/1ps
module tile_lanes
  import tile_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int Y_MAX    = Y_MAX_D,
  parameter int TILE_H   = TILE_H_D,
  parameter int HIT_LINE = HIT_LINE_D,
  parameter int SPEED_W  = 4
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic [LANES-1:0]     spawn,
  input  logic [LANES-1:0]     key_hit,
  input  logic [SPEED_W-1:0]   speed,
  output logic [LANES*Y_W-1:0] tile_y,
  output logic [LANES-1:0]     tile_active,
  output logic [LANES-1:0]     hit_ok,
  output logic [LANES-1:0]     hit_bad,
  output logic [LANES-1:0]     miss,
  output logic [15:0]          score
);

  logic [LANES-1:0] hit_now;
  logic [16:0]      score_sum;
  logic [15:0]      score_next;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      tile_lane #(
        .Y_MAX    (Y_MAX),
        .TILE_H   (TILE_H),
        .HIT_LINE (HIT_LINE),
        .SPEED_W  (SPEED_W)
      ) u_lane (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .spawn       (spawn[gi]),
        .key_hit     (key_hit[gi]),
        .speed       (speed),
        .tile_y      (tile_y[gi*Y_W +: Y_W]),
        .tile_active (tile_active[gi]),
        .hit_ok      (hit_ok[gi]),
        .hit_bad     (hit_bad[gi]),
        .miss        (miss[gi]),
        .hit_now     (hit_now[gi])
      );
    end
  endgenerate

  // Add the popcount of this frame's hits in one step; the 17th bit
  // catches overflow so the score can clamp at all-ones.
  always_comb begin
    score_sum = {1'b0, score};
    for (int i = 0; i < LANES; i++) begin
      score_sum = score_sum + 17'(hit_now[i]);
    end
    score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      score <= '0;
    end else begin
      score <= score_next;
    end
  end

endmodule
